// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the cache memory arbiter and the caches / pipelined main memory.
// The master side is the arbiter; the slave side is the caches plus the memory.
interface cache_mem_arbiter_if;
    logic        i_miss;
    logic [15:0] i_miss_addr;
    logic        d_miss;
    logic [15:0] d_miss_addr;
    logic        d_wr_req;
    logic [15:0] d_wr_addr;
    logic [15:0] d_wr_data;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_we;
    logic        d_fill_we;
    logic        i_fill_done;
    logic        d_fill_done;
    logic        d_wr_ack;
    logic        busy;

    modport master (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr,
        input  d_wr_req, d_wr_addr, d_wr_data,
        input  mem_rdata, mem_rvalid,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_data, fill_word, i_fill_we, d_fill_we,
        output i_fill_done, d_fill_done, d_wr_ack, busy
    );

    modport slave (
        output i_miss, i_miss_addr, d_miss, d_miss_addr,
        output d_wr_req, d_wr_addr, d_wr_data,
        output mem_rdata, mem_rvalid,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_data, fill_word, i_fill_we, d_fill_we,
        input  i_fill_done, d_fill_done, d_wr_ack, busy
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Grants the shared memory port to a D-cache store, a D-cache fill or an I-cache fill,
// issues block reads back-to-back and steers returning words into the owning cache.
module cache_mem_arbiter #(
    parameter int WORDS       = 8,
    parameter int MEM_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_mem_arbiter_if.master  bus
);
    localparam int WW = $clog2(WORDS);
    localparam int CW = WW + 1;
    localparam int BW = 15 - WW;

    typedef enum logic [1:0] {IDLE, WRITE, FILL_D, FILL_I} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_last_d;
    logic [BW-1:0]   r_blk;
    logic [CW-1:0]   r_ic;
    logic [CW-1:0]   r_rc;
    logic [15:0]     r_wr_addr;
    logic [15:0]     r_wr_data;

    logic            w_fill;
    logic            w_issue;
    logic            w_rx;
    logic            w_last;

    assign w_fill  = (r_state == FILL_D) || (r_state == FILL_I);
    assign w_issue = w_fill && (r_ic < CW'(WORDS));
    // rvalid outside a fill is a stray return from an abandoned block and is dropped
    assign w_rx    = w_fill && bus.mem_rvalid;
    assign w_last  = w_rx && (r_rc == CW'(WORDS - 1));

    always_comb begin
        // NOTE: every output and the next state get a default first so no latch is inferred.
        w_next          = r_state;
        bus.mem_en      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.fill_data   = '0;
        bus.fill_word   = '0;
        bus.i_fill_we   = 1'b0;
        bus.d_fill_we   = 1'b0;
        bus.i_fill_done = 1'b0;
        bus.d_fill_done = 1'b0;
        bus.d_wr_ack    = 1'b0;
        bus.busy        = (r_state != IDLE);

        case (r_state)
            IDLE: begin
                // last_d lets a waiting I miss jump ahead of back-to-back D traffic
                if (r_last_d && bus.i_miss) w_next = FILL_I;
                else if (bus.d_wr_req)      w_next = WRITE;
                else if (bus.d_miss)        w_next = FILL_D;
                else if (bus.i_miss)        w_next = FILL_I;
            end
            WRITE: begin
                bus.mem_en    = 1'b1;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = r_wr_addr;
                bus.mem_wdata = r_wr_data;
                bus.d_wr_ack  = 1'b1;
                w_next        = IDLE;
            end
            default: begin
                if (w_issue) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = {r_blk, r_ic[WW-1:0], 1'b0};
                end
                if (w_rx) begin
                    bus.fill_data = bus.mem_rdata;
                    bus.fill_word = 3'(r_rc);
                    if (r_state == FILL_I) begin
                        bus.i_fill_we   = 1'b1;
                        bus.i_fill_done = w_last;
                    end else begin
                        bus.d_fill_we   = 1'b1;
                        bus.d_fill_done = w_last;
                    end
                end
                if (w_last) w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_last_d  <= 1'b0;
            r_blk     <= '0;
            r_ic      <= '0;
            r_rc      <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register update sees pre-edge values.
            r_state <= w_next;
            if (r_state == IDLE) begin
                case (w_next)
                    WRITE: begin
                        r_last_d  <= 1'b1;
                        r_wr_addr <= bus.d_wr_addr;
                        r_wr_data <= bus.d_wr_data;
                    end
                    FILL_D: begin
                        r_last_d <= 1'b1;
                        r_blk    <= bus.d_miss_addr[15:WW+1];
                        r_ic     <= '0;
                        r_rc     <= '0;
                    end
                    FILL_I: begin
                        r_last_d <= 1'b0;
                        r_blk    <= bus.i_miss_addr[15:WW+1];
                        r_ic     <= '0;
                        r_rc     <= '0;
                    end
                    default: ;
                endcase
            end
            if (w_issue) r_ic <= r_ic + CW'(1);
            if (w_rx)    r_rc <= r_rc + CW'(1);
        end
    end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Sequencer and arbiter for the single shared main-memory port behind the I-cache and D-cache of the pipelined CPU. It grants the port to one requester at a time: a D-cache write-through store, a D-cache block fill, or an I-cache block fill. For fills it issues the block's word reads back-to-back into the pipelined memory and steers returning words, with their word index, into the owning cache. It pulses a per-requester done/ack that the cache uses to release its stall (`memStall` / `insStall`).

## Interface
- `WORDS` — default 8 — words per cache block, 16-bit words; block = 16 bytes.
- `MEM_LATENCY` — default 4 — cycles from read issue to `mem_rvalid`; memory accepts one read per cycle.
- `clk` — in, 1 — the single clock; everything is on the rising edge.
- `rst_n` — in, 1 — reset; asynchronous, active-low.
- `i_miss` — in, 1 — I-cache fill request; level, held until `i_fill_done`.
- `i_miss_addr` — in, 16 — byte address of the I miss.
- `d_miss` — in, 1 — D-cache fill request; level, held until `d_fill_done`.
- `d_miss_addr` — in, 16 — byte address of the D miss.
- `d_wr_req` — in, 1 — write-through store request; held until `d_wr_ack`.
- `d_wr_addr` — in, 16 — store address.
- `d_wr_data` — in, 16 — store data.
- `mem_en` — out, 1 — memory command valid.
- `mem_wr` — out, 1 — 1 = write, 0 = read; valid only with `mem_en`.
- `mem_addr` — out, 16 — memory byte address.
- `mem_wdata` — out, 16 — write data.
- `mem_rdata` — in, 16 — read data.
- `mem_rvalid` — in, 1 — read data valid.
- `fill_data` — out, 16 — word being filled; equals `mem_rdata`.
- `fill_word` — out, 3 — word index within the block.
- `i_fill_we` — out, 1 — write `fill_data` into the I-cache line.
- `d_fill_we` — out, 1 — write `fill_data` into the D-cache line.
- `i_fill_done` — out, 1 — one-cycle pulse on the last I fill word.
- `d_fill_done` — out, 1 — one-cycle pulse on the last D fill word.
- `d_wr_ack` — out, 1 — one-cycle pulse; the store is committed to memory.
- `busy` — out, 1 — the port is granted; high in any state other than IDLE.

## Operation
- States:
  - IDLE
  - WRITE
  - FILL_D
  - FILL_I
- Reset: state = IDLE, counters = 0, `last_d` flag = 0. Every output is 0.
- Arbitration in IDLE, sampled at the rising edge:
  - `d_wr_req` has highest priority.
  - Next is `d_miss`.
  - Then `i_miss`.
  - Exception: if `last_d` = 1 and `i_miss` = 1, FILL_I wins over both D requests.
- `last_d` is set on any D grant (WRITE or FILL_D) and cleared on an I grant. This prevents I starvation.
- A store always wins over a D miss. Write-through data therefore reaches memory before any following D refill.
- WRITE (1 cycle): drive `mem_en` = 1, `mem_wr` = 1, `mem_addr` = `d_wr_addr`, `mem_wdata` = `d_wr_data`, and `d_wr_ack` = 1. Next state is IDLE.
- FILL on grant:
  - Latch `blk` = `addr[15:4]` of the winning requester.
  - Clear the issue counter `ic` and the receive counter `rc`.
- FILL issue:
  - While `ic` < `WORDS`: drive `mem_en` = 1, `mem_wr` = 0, `mem_addr` = {`blk`, `ic[2:0]`, 1'b0}, then increment `ic`.
  - Once `ic` = `WORDS`, stop issuing; `ic` saturates.
- FILL receive, on each `mem_rvalid`:
  - `fill_data` = `mem_rdata`, `fill_word` = `rc`.
  - The owner's `*_fill_we` = 1.
  - Increment `rc`.
- Completion: on the rvalid with `rc` = `WORDS`−1, also pulse the owner's `*_fill_done`. Next state is IDLE.
- Words fill in order 0..7; there is no critical-word-first.
- `mem_rvalid` outside FILL_D/FILL_I is ignored: no `we`, no counter change.
- A requester that drops its request mid-fill does not abort the fill; the full block is still written and done still pulses.
- Request inputs and addresses are sampled only at grant. Changes during the transaction are ignored.
- Reset asserted mid-transaction forces IDLE immediately (asynchronous) and clears all pulses. Partial fills are abandoned; the cache must reissue its miss.

## Timing
- All outputs are decoded from registered state and counters. `fill_*` follows `mem_rvalid` combinationally.
- Let grant edge = G, with cycle 1 being the cycle after G.
- WRITE:
  - `d_wr_ack` and the write command in cycle 1.
  - IDLE in cycle 2, where a new grant can be sampled at the end of cycle 2.
- FILL:
  - Issues in cycles 1..8.
  - `rvalid`/`we` in cycles 1+`MEM_LATENCY` .. 8+`MEM_LATENCY` (5..12 by default).
  - done in cycle 12.
  - IDLE in cycle 13.
  - Block-miss penalty seen by the cache = 12 cycles from grant.
- Back-to-back: the minimum gap between transactions is one IDLE cycle.
- `busy` = 1 exactly in cycles 1..(end of transaction).

## Test plan
- **Reset:**
  - Stimulus: hold `rst_n` = 0 with all requests high.
  - Required: all outputs 0 and `busy` = 0.
  - Release: the first grant is the store; `d_wr_ack` fires in cycle 1 after the first edge.
- **I fill:**
  - Stimulus: `i_miss` = 1 with `i_miss_addr` = 0x1236.
  - Required issues: 0x1230, 0x1232, … 0x123E in cycles 1..8.
  - Required fill: `i_fill_we` in cycles 5..12 with `fill_word` 0..7 and data matching the memory model.
  - Required completion: `i_fill_done` only in cycle 12; `d_fill_we` never.
- **Priority:**
  - Stimulus: `d_wr_req`, `d_miss` and `i_miss` asserted together with `last_d` = 0.
  - Required grant order: WRITE, then FILL_I (because `last_d` is now set), then FILL_D.
- **Anti-starvation:**
  - Stimulus: `d_miss` re-asserted immediately after each done, with `i_miss` held.
  - Required: grants alternate D, I, D, I.
- **Drop mid-fill:**
  - Stimulus: deassert `d_miss` in cycle 3 of a D fill.
  - Required: all 8 `d_fill_we` still occur and `d_fill_done` fires in cycle 12.
- **Reset mid-fill and stray rvalid:**
  - Stimulus: assert `rst_n` = 0 in cycle 6 of a fill, then release; late `mem_rvalid` pulses arrive in IDLE.
  - Required: state IDLE, no `we` and no done for the late pulses; the next `i_miss` produces a clean 12-cycle fill with `fill_word` starting at 0.
